ram_block_copy: RTL and testbench



---
 rtl/ram_block_copy.sv | 154 +++++++++++++++
 tb/tb_ram_block_copy.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_block_copy.sv
// Purpose : word-granular block-copy engine driving the single-word port (B) of dp_ram.
// Latency : start sampled at edge 0; copy reads word k in cycle 2k+1 and writes it in cycle 2k+2;
//           done_o pulses in cycle 2N+1 (cycle 1 for N=0); fill mode writes word k in cycle k+1.
// Backpr. : none; the RAM always accepts and start_i is only sampled while idle.
//
// Ports   : clk/rst_n (synchronous, active-low); start_i, src_addr_i, dst_addr_i, len_i request;
//           busy_o/done_o status; mem_en_o/mem_we_o/mem_be_o/mem_addr_o/mem_wdata_o/mem_rdata_i RAM port.
// Option  : RAM_BLOCK_COPY_FILL_EN adds fill_i/fill_data_i for a constant-pattern fill mode.
module ram_block_copy #(
    parameter int ADDR_WIDTH = 20,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] src_addr_i,
    input  logic [ADDR_WIDTH-1:0] dst_addr_i,
    input  logic [LEN_WIDTH-1:0]  len_i,
`ifdef RAM_BLOCK_COPY_FILL_EN
    input  logic                  fill_i,
    input  logic [31:0]           fill_data_i,
`endif
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  mem_en_o,
    output logic                  mem_we_o,
    output logic [3:0]            mem_be_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [31:0]           mem_wdata_o,
    input  logic [31:0]           mem_rdata_i
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RD,
        S_WR,
        S_DONE
    } state_t;

    state_t                state_q;
    state_t                state_nxt;
    logic [ADDR_WIDTH-1:0] src_q;
    logic [ADDR_WIDTH-1:0] dst_q;
    logic [LEN_WIDTH-1:0]  rem_q;
    logic                  fill_q;
    logic [31:0]           fill_dat_q;
    logic                  fill_req;
    logic [31:0]           fill_req_dat;

`ifdef RAM_BLOCK_COPY_FILL_EN
    assign fill_req     = fill_i;
    assign fill_req_dat = fill_data_i;
`else
    assign fill_req     = 1'b0;
    assign fill_req_dat = 32'h0;
`endif

    // Word alignment is applied when the request is captured, so every
    // address the engine emits has [1:0] = 0.
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(3);
    localparam logic [ADDR_WIDTH-1:0] WORD_STEP  = ADDR_WIDTH'(4);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            src_q      <= '0;
            dst_q      <= '0;
            rem_q      <= '0;
            fill_q     <= 1'b0;
            fill_dat_q <= 32'h0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        src_q      <= src_addr_i & ALIGN_MASK;
                        dst_q      <= dst_addr_i & ALIGN_MASK;
                        rem_q      <= len_i;
                        fill_q     <= fill_req;
                        fill_dat_q <= fill_req_dat;
                    end
                end
                S_WR: begin
                    // Both pointers wrap modulo 2^ADDR_WIDTH by plain overflow.
                    src_q <= src_q + WORD_STEP;
                    dst_q <= dst_q + WORD_STEP;
                    rem_q <= rem_q - LEN_WIDTH'(1);
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        state_nxt   = state_q;
        busy_o      = 1'b0;
        done_o      = 1'b0;
        mem_en_o    = 1'b0;
        mem_we_o    = 1'b0;
        mem_be_o    = 4'h0;
        mem_addr_o  = '0;
        mem_wdata_o = 32'h0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    if (len_i == '0) begin
                        state_nxt = S_DONE;
                    end else if (fill_req) begin
                        state_nxt = S_WR;
                    end else begin
                        state_nxt = S_RD;
                    end
                end
            end
            S_RD: begin
                busy_o     = 1'b1;
                mem_en_o   = 1'b1;
                mem_addr_o = src_q;
                state_nxt  = S_WR;
            end
            S_WR: begin
                busy_o      = 1'b1;
                mem_en_o    = 1'b1;
                mem_we_o    = 1'b1;
                mem_be_o    = 4'hF;
                mem_addr_o  = dst_q;
                // Read data from the preceding RD cycle is forwarded straight to the write port.
                mem_wdata_o = fill_q ? fill_dat_q : mem_rdata_i;
                // rem_q still holds the pre-decrement count here.
                if (rem_q != LEN_WIDTH'(1)) begin
                    state_nxt = fill_q ? S_WR : S_RD;
                end else begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                busy_o    = 1'b1;
                done_o    = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ram_block_copy.sv
`timescale 1ns/1ps
module tb_ram_block_copy;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [19:0] src;
    logic [19:0] dst;
    logic [15:0] len;
    logic        fill;
    logic [31:0] fill_dat;
    logic        busy, done, en, we;
    logic [3:0]  be;
    logic [19:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ram_block_copy #(.ADDR_WIDTH(20), .LEN_WIDTH(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start),
        .src_addr_i  (src),
        .dst_addr_i  (dst),
        .len_i       (len),
`ifdef RAM_BLOCK_COPY_FILL_EN
        .fill_i      (fill),
        .fill_data_i (fill_dat),
`endif
        .busy_o      (busy),
        .done_o      (done),
        .mem_en_o    (en),
        .mem_we_o    (we),
        .mem_be_o    (be),
        .mem_addr_o  (addr),
        .mem_wdata_o (wdata),
        .mem_rdata_i (rdata)
    );

    // Initial RAM contents: a fixed pattern for the first test region, a hash elsewhere.
    function automatic logic [31:0] init_val(input int unsigned w);
        if (w >= 64 && w < 68) return 32'h11111111 * (w - 63);
        return (w * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    // RAM model on port B: one-cycle registered read, byte-enabled write.
    logic [31:0] ram     [0:262143];
    logic        wr_flag [0:262143];
    logic        mem_clr = 1'b1;

    function automatic logic [31:0] ram_rd(input logic [19:0] a);
        int unsigned w;
        w = int'(a[19:2]);
        return wr_flag[w] ? ram[w] : init_val(w);
    endfunction

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 262144; i++) wr_flag[i] <= 1'b0;
            rdata <= 32'h0;
        end else if (en) begin
            if (we) begin
                logic [31:0] t;
                t = ram_rd(addr);
                for (int b = 0; b < 4; b++)
                    if (be[b]) t[8*b +: 8] = wdata[8*b +: 8];
                ram[addr[19:2]]     <= t;
                wr_flag[addr[19:2]] <= 1'b1;
            end else begin
                rdata <= ram_rd(addr);
            end
        end
    end

    // Reference memory: what the RAM should hold after each copy, word by word.
    logic [31:0] ref_mem [int];

    function automatic logic [31:0] ref_rd(input logic [19:0] a);
        int w;
        w = int'(a[19:2]);
        return ref_mem.exists(w) ? ref_mem[w] : init_val(w);
    endfunction

    function automatic void ref_wr(input logic [19:0] a, input logic [31:0] v);
        ref_mem[int'(a[19:2])] = v;
    endfunction

    function automatic logic [27:0] stat();
        return {busy, done, en, we, be, addr};
    endfunction

    function automatic logic [27:0] mk(input bit b, input bit d, input bit e, input bit w,
                                       input logic [3:0] bev, input logic [19:0] a);
        return {b, d, e, w, bev, a};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Called just after the start-sampling edge (edge 0). Walks cycles 1..last+1
    // comparing the bus against the copy/fill rules, updating the reference memory.
    task automatic observe(input logic [19:0] s, input logic [19:0] d, input int n,
                           input bit fl, input logic [31:0] fd, input bit hold);
        logic [19:0] sa, da, a;
        logic [31:0] v;
        int          last, k;
        sa   = s & 20'hFFFFC;
        da   = d & 20'hFFFFC;
        v    = 32'h0;
        last = fl ? n + 1 : 2 * n + 1;
        for (int c = 1; c <= last + 1; c++) begin
            #1;
            if (c == 1 && !hold) start = 1'b0;
            if (c == last) begin
                chk("done_cycle", stat(), mk(1, 1, 0, 0, 4'h0, 20'h0));
            end else if (c == last + 1) begin
                chk("idle_after", stat(), mk(0, 0, 0, 0, 4'h0, 20'h0));
            end else if (fl) begin
                k = c - 1;
                a = da + 20'(4 * k);
                ref_wr(a, fd);
                chk("fill_bus", stat(), mk(1, 0, 1, 1, 4'hF, a));
                chk("fill_wdata", wdata, fd);
            end else if (c % 2 == 1) begin
                k = (c - 1) / 2;
                a = sa + 20'(4 * k);
                v = ref_rd(a);
                chk("rd_bus", stat(), mk(1, 0, 1, 0, 4'h0, a));
            end else begin
                k = (c - 2) / 2;
                a = da + 20'(4 * k);
                ref_wr(a, v);
                chk("wr_bus", stat(), mk(1, 0, 1, 1, 4'hF, a));
                chk("wr_wdata", wdata, v);
            end
            if (c <= last) @(posedge clk);
        end
    endtask

    task automatic mem_check(input logic [19:0] d, input int n);
        logic [19:0] a;
        for (int k = 0; k < n; k++) begin
            a = (d & 20'hFFFFC) + 20'(4 * k);
            chk("mem_word", ram_rd(a), ref_rd(a));
        end
    endtask

    task automatic go(input logic [19:0] s, input logic [19:0] d, input int n,
                      input bit fl, input logic [31:0] fd);
        @(negedge clk);
        src      = s;
        dst      = d;
        len      = 16'(n);
        fill     = fl;
        fill_dat = fd;
        start    = 1'b1;
        @(posedge clk);
        observe(s, d, n, fl, fd, 1'b0);
        mem_check(d, n);
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        src      = 20'h0;
        dst      = 20'h0;
        len      = 16'h0;
        fill     = 1'b0;
        fill_dat = 32'h0;
        repeat (2) @(posedge clk);
        mem_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_stat", stat(), 28'h0);
        chk("reset_wdata", wdata, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic copy with known source pattern.
        go(20'h00100, 20'h00200, 4, 1'b0, 32'h0);
        chk("dst_first", ram_rd(20'h00200), 32'h11111111);
        chk("dst_last", ram_rd(20'h0020C), 32'h44444444);

        // Zero length: done in cycle 1, no RAM access.
        go(20'h00100, 20'h00400, 0, 1'b0, 32'h0);

        // Source wraps past the top of the address space.
        go(20'hFFFFC, 20'h00010, 2, 1'b0, 32'h0);

        // Unaligned addresses are truncated to word boundaries.
        go(20'h00103, 20'h00202, 1, 1'b0, 32'h0);

        // start held high: one transfer, an idle cycle, then a fresh transfer.
        @(negedge clk);
        src   = 20'h00120;
        dst   = 20'h00240;
        len   = 16'd3;
        fill  = 1'b0;
        start = 1'b1;
        @(posedge clk);
        observe(20'h00120, 20'h00240, 3, 1'b0, 32'h0, 1'b1);
        @(posedge clk);
        observe(20'h00120, 20'h00240, 3, 1'b0, 32'h0, 1'b0);
        mem_check(20'h00240, 3);

        // Reset in cycle 3 of an 8-word copy: only word 0 lands, no done pulse.
        @(negedge clk);
        src   = 20'h00500;
        dst   = 20'h00600;
        len   = 16'd8;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_stat", stat(), 28'h0);
        chk("abort_wdata", wdata, 32'h0);
        rst_n = 1'b1;
        ref_wr(20'h00600, ref_rd(20'h00500));
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            chk("abort_quiet", stat(), 28'h0);
        end
        chk("abort_word0", ram_rd(20'h00600), ref_rd(20'h00600));
        chk("abort_word1", ram_rd(20'h00604), init_val(32'h181));

        // Randomised copies in a small window so regions often overlap.
        for (int i = 0; i < 10; i++) begin
            logic [19:0] rs, rd;
            rs = 20'h00800 + 20'($urandom_range(0, 40)) * 20'd4 + 20'($urandom_range(0, 3));
            rd = 20'h00800 + 20'($urandom_range(0, 40)) * 20'd4 + 20'($urandom_range(0, 3));
            go(rs, rd, int'($urandom_range(0, 6)), 1'b0, 32'h0);
        end

`ifdef RAM_BLOCK_COPY_FILL_EN
        go(20'h00000, 20'h00300, 3, 1'b1, 32'hDEADBEEF);
        chk("fill_word2", ram_rd(20'h00308), 32'hDEADBEEF);
        go(20'h00000, 20'h00700, 0, 1'b1, 32'hCAFEF00D);
        for (int i = 0; i < 4; i++) begin
            logic [31:0] fv;
            fv = $urandom;
            go(20'h00900, 20'h00A00 + 20'($urandom_range(0, 15)) * 20'd4,
               int'($urandom_range(1, 5)), 1'($urandom_range(0, 1)), fv);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
